// File: rtl/iobus_pkg.sv
// iobus_pkg: shared IOBUS addresses, UART TX state encoding and status bit positions
package iobus_pkg;
  localparam logic [31:0] DATA_ADDR   = 32'h1100_00C0;
  localparam logic [31:0] STATUS_ADDR = 32'h1100_00C4;
  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is taken when a pop frees the slot in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic push_ok, pop_ok;
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign dout    = mem[rd_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // pointer and occupancy next state
  always_comb begin
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end
  // pointer and occupancy registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset; occupancy governs validity
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_q] <= din;
  end
endmodule

// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx: IOBUS-mapped 8N1 UART transmitter with byte FIFO and sticky overflow status
module iobus_uart_tx
  import iobus_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR_P   = DATA_ADDR,
  parameter logic [31:0] STATUS_ADDR_P = STATUS_ADDR,
  parameter int          CLKS_PER_BIT  = 434,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  uart_tx_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic ovf_q, ovf_d;
  logic push, pop, clr, tick, full, empty;
  logic [7:0] head;
  logic [CW-1:0] count;
  logic [31:0] status;
  logic unused_ok;
  assign unused_ok = ^IOBUS_OUT[31:8];
  assign push = IOBUS_WR && IOBUS_ADDR == DATA_ADDR_P;
  assign clr  = IOBUS_WR && IOBUS_ADDR == STATUS_ADDR_P;
  assign tick = baud_q == BW'(CLKS_PER_BIT - 1);
  assign TX   = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK), .RST(RST), .push(push), .pop(pop), .din(IOBUS_OUT[7:0]),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  // frame sequencing: pop, start bit, 8 data bits LSB first, stop bit, optional immediate next pop
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = head;
        state_d = START;
      end
      START: if (tick) begin
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        pop     = !empty;
        shift_d = empty ? shift_q : head;
        state_d = empty ? IDLE : START;
      end
    endcase
  end
  // sticky overflow: a rejected push sets it, a status write clears it
  always_comb ovf_d = clr ? 1'b0 : (push && full && !pop) ? 1'b1 : ovf_q;
  // status word and address-qualified read mux
  always_comb begin
    status                   = '0;
    status[ST_BUSY]          = state_q != IDLE;
    status[ST_EMPTY]         = empty;
    status[ST_FULL]          = full;
    status[ST_OVF]           = ovf_q;
    status[ST_COUNT +: 8]    = 8'(count);
    IOBUS_IN                 = IOBUS_ADDR == STATUS_ADDR_P ? status : 32'h0;
  end
  // transmitter state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_iobus_uart_tx.sv
// tb_iobus_uart_tx: scoreboard bench decoding TX frames against the bytes written
module tb_iobus_uart_tx;
  localparam logic [31:0] DADDR = 32'h1100_00C0;
  localparam logic [31:0] SADDR = 32'h1100_00C4;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IOBUS_ADDR = SADDR;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        TX;
  int n_chk = 0, n_fail = 0, frames = 0, rst_gen = 0;
  logic [7:0] sb_q[$];
  iobus_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .TX(TX)
  );
  always #10 CLK = ~CLK;
  always @(posedge RST) rst_gen <= rst_gen + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = SADDR;
  endtask
  task automatic rd(output logic [31:0] v);
    IOBUS_ADDR = SADDR;
    #1 v = IOBUS_IN;
  endtask
  task automatic wait_idle(input int max_cycles);
    logic [31:0] v;
    int k;
    for (k = 0; k < max_cycles; k++) begin
      @(negedge CLK);
      rd(v);
      if (v == 32'h2) break;
    end
    check("idle_wait", 64'(k < max_cycles), 64'd1);
  endtask
  // frame decoder: start detected on first low sample, bits sampled mid-cell
  initial begin : monitor
    logic [7:0] b;
    logic s0, sp;
    int g;
    forever begin
      @(negedge CLK);
      if (!RST && TX === 1'b0) begin
        g = rst_gen;
        repeat (2) @(negedge CLK);
        s0 = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge CLK);
          b[i] = TX;
        end
        repeat (4) @(negedge CLK);
        sp = TX;
        if (g == rst_gen && !RST) begin
          frames++;
          check("start_bit", 64'(s0), 64'd0);
          check("stop_bit", 64'(sp), 64'd1);
          if (sb_q.size() == 0) check("unexpected_frame", 64'd1, 64'd0);
          else check("frame_byte", 64'(b), 64'(sb_q.pop_front()));
        end
      end
    end
  end
  initial begin : stim
    logic [31:0] v;
    logic [63:0] got_tx, exp_tx, got_bz, exp_bz;
    logic [7:0] byte_v;
    int f0, busy_n, falls, lows;
    logic prev;
    #1;
    check("reset_tx", 64'(TX), 64'd1);
    rd(v);
    check("reset_status", 64'(v), 64'h2);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    rd(v);
    check("post_reset_status", 64'(v), 64'h2);
    @(negedge CLK);
    // single byte, exact waveform and busy window
    byte_v = 8'h55;
    sb_q.push_back(byte_v);
    wr(DADDR, 32'hFFFF_FF55);
    got_tx = '0; exp_tx = '0; got_bz = '0; exp_bz = '0;
    for (int k = 0; k < 42; k++) begin
      if (k > 0) @(negedge CLK);
      #1;
      got_tx[k] = TX;
      got_bz[k] = IOBUS_IN[0];
      exp_tx[k] = (k >= 1 && k <= 4) ? 1'b0 : (k >= 5 && k <= 36) ? byte_v[(k-5)/4] : 1'b1;
      exp_bz[k] = k >= 1 && k <= 40;
    end
    check("tx_wave_55", got_tx, exp_tx);
    check("busy_wave_55", got_bz, exp_bz);
    wait_idle(20);
    check("frames_55", 64'(frames), 64'd1);
    // three back-to-back bytes, contiguous frames
    f0 = frames;
    foreach (sb_q[i]) ;
    sb_q.push_back(8'hA5); sb_q.push_back(8'h3C); sb_q.push_back(8'hFF);
    wr(DADDR, 32'hA5);
    wr(DADDR, 32'h3C);
    wr(DADDR, 32'hFF);
    busy_n = 0; falls = 0; prev = 1'b1;
    for (int k = 0; k < 140; k++) begin
      if (k > 0) @(negedge CLK);
      #1;
      busy_n += int'(IOBUS_IN[0]);
      if (prev && !IOBUS_IN[0]) falls++;
      prev = IOBUS_IN[0];
    end
    check("busy_cycles_3", 64'(busy_n), 64'd119);
    check("busy_falls_3", 64'(falls), 64'd1);
    wait_idle(20);
    rd(v);
    check("status_after_3", 64'(v), 64'h2);
    check("frames_3", 64'(frames - f0), 64'd3);
    // overflow: six writes into a depth-4 FIFO
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb_q.push_back(8'(8'h11 * (i + 1)));
      wr(DADDR, 32'(8'h11 * (i + 1)));
    end
    rd(v);
    check("status_overflow", 64'(v), 64'h0000_040D);
    @(negedge CLK);
    IOBUS_ADDR = 32'h1100_0000;
    IOBUS_OUT  = 32'h0000_0077;
    IOBUS_WR   = 1'b1;
    #1 check("other_addr_in", 64'(IOBUS_IN), 64'h0);
    @(negedge CLK);
    IOBUS_WR = 1'b0;
    rd(v);
    check("status_other_addr", 64'(v), 64'h0000_040D);
    @(negedge CLK);
    wr(SADDR, 32'hFFFF_FFFF);
    rd(v);
    check("status_ovf_clear", 64'(v), 64'h0000_0405);
    wait_idle(300);
    check("frames_ovf", 64'(frames - f0), 64'd5);
    check("queue_drained", 64'(sb_q.size()), 64'd0);
    // reset mid-DATA with two bytes queued
    f0 = frames;
    wr(DADDR, 32'hAA);
    wr(DADDR, 32'hBB);
    wr(DADDR, 32'hCC);
    repeat (12) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("mid_reset_tx", 64'(TX), 64'd1);
    rd(v);
    check("mid_reset_status", 64'(v), 64'h2);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      lows += int'(!TX);
    end
    check("post_reset_tx_low", 64'(lows), 64'd0);
    check("post_reset_frames", 64'(frames - f0), 64'd0);
    rd(v);
    check("post_reset_status2", 64'(v), 64'h2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
